// File: rtl/bcd_stream_to_bin.sv
// bcd_stream_to_bin
// -----------------
// Digit-serial BCD-to-binary decoder. Symbols arrive most-significant digit
// first; an optional leading Minus (4'hA) makes the number negative and the
// Empty code (4'hF) terminates it. The signed result and an error flag are
// presented over a valid/ready output handshake.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low. This block never withdraws out_valid before out_ready is seen.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_digit holds a symbol
//   in_ready   block accepts a symbol this cycle (low while a result waits)
//   in_digit   0-9 digit, 4'hA Minus, 4'hF Empty, 4'hB-4'hE illegal
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_value  signed two's-complement result (0 on error)
//   out_error  number malformed or out of range
//   busy       a number is partially received
module bcd_stream_to_bin #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_digit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_error,
    output logic             busy
);

    localparam int AW = WIDTH + 4;
    localparam logic [3:0] SYM_MINUS = 4'hA;
    localparam logic [3:0] SYM_EMPTY = 4'hF;
    localparam logic [AW-1:0] LIM_NEG = AW'(1) << (WIDTH - 1);
    localparam logic [AW-1:0] LIM_POS = LIM_NEG - AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // FSM state is a named enum signal so checkers can bind to it directly.
    state_t state, state_next;

    logic [AW-1:0]    acc, acc_next;
    logic [3:0]       count, count_next;
    logic             neg, neg_next;

    logic             accept;
    logic             is_digit;
    logic [AW-1:0]    acc_dig;
    logic [AW-1:0]    acc_neg;
    logic [AW-1:0]    limit;
    logic [3:0]       count_inc;
    logic             dig_bad;
    logic             load_out;
    logic [WIDTH-1:0] value_next;
    logic             error_next;

    // in_ready is held low while reset is asserted so every output reads 0.
    assign in_ready  = rst_n && (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACCUM) || (state == DRAIN);
    assign accept    = in_valid && in_ready;
    assign is_digit  = (in_digit <= 4'd9);

    // acc*10 + d. With acc bounded by 2^(WIDTH-1) the sum stays below
    // 2^(WIDTH+3), so the WIDTH+4 bit accumulator never wraps.
    assign acc_dig   = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, in_digit};
    assign acc_neg   = ~acc + AW'(1);
    assign limit     = neg ? LIM_NEG : LIM_POS;
    assign count_inc = count + 4'd1;
    assign dig_bad   = (count_inc > 4'(DIGITS)) || (acc_dig > limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            neg   <= neg_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        neg_next   = neg;
        load_out   = 1'b0;
        value_next = '0;
        error_next = 1'b0;

        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (is_digit) begin
                        // In IDLE acc is 0, so this also loads the first digit.
                        acc_next   = acc_dig;
                        count_next = count_inc;
                        state_next = dig_bad ? DRAIN : ACCUM;
                    end else if (in_digit == SYM_EMPTY) begin
                        state_next = DONE;
                        load_out   = 1'b1;
                        if (state == ACCUM && count != 4'd0) begin
                            value_next = neg ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0];
                        end else begin
                            // Empty number or a lone Minus.
                            error_next = 1'b1;
                        end
                    end else if (in_digit == SYM_MINUS && state == IDLE) begin
                        neg_next   = 1'b1;
                        count_next = 4'd0;
                        state_next = ACCUM;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && in_digit == SYM_EMPTY) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                    error_next = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = 4'd0;
                    neg_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only move on entry to DONE, so they stay stable for
    // the whole time the result is offered and afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_value <= '0;
            out_error <= 1'b0;
        end else if (load_out) begin
            out_value <= value_next;
            out_error <= error_next;
        end
    end

endmodule

// File: tb/tb_bcd_stream_to_bin.sv
// Bench for bcd_stream_to_bin. Two instances share one input stream: the
// default build (DIGITS=4, WIDTH=16) and a narrow build (DIGITS=3, WIDTH=8).
// Both accept at the same rate, so they finish every number together.
module tb_bcd_stream_to_bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_digit;
    logic        out_ready;

    logic        in_ready16, out_valid16, out_error16, busy16;
    logic [15:0] out_value16;
    logic        in_ready8, out_valid8, out_error8, busy8;
    logic [7:0]  out_value8;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_stream_to_bin u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .in_digit  (in_digit),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .out_value (out_value16),
        .out_error (out_error16),
        .busy      (busy16)
    );

    bcd_stream_to_bin #(.DIGITS(3), .WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_digit  (in_digit),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_value (out_value8),
        .out_error (out_error8),
        .busy      (busy8)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive n symbols, packed most-significant nibble first, one per cycle.
    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic send_stream(input logic [31:0] syms, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("busy16_mid", busy16, 1'b1);
                check("busy8_mid", busy8, 1'b1);
            end
            in_valid = 1'b1;
            in_digit = syms[4*(n-1-i) +: 4];
            check("in_ready16", in_ready16, 1'b1);
            check("in_ready8", in_ready8, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called one cycle after the terminator was accepted.
    task automatic collect(input logic [15:0] v16, input logic e16,
                           input logic [7:0] v8, input logic e8);
        check("out_valid16", out_valid16, 1'b1);
        check("out_valid8", out_valid8, 1'b1);
        check("out_value16", out_value16, v16);
        check("out_error16", out_error16, e16);
        check("out_value8", out_value8, v8);
        check("out_error8", out_error8, e8);
        check("busy16_done", busy16, 1'b0);
        check("in_ready16_done", in_ready16, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid16_drop", out_valid16, 1'b0);
        check("out_valid8_drop", out_valid8, 1'b0);
        check("in_ready16_idle", in_ready16, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = 4'h0;
        out_ready = 1'b0;

        #12;
        check("rst_out_valid", out_valid16, 1'b0);
        check("rst_out_value", out_value16, 16'h0);
        check("rst_out_error", out_error16, 1'b0);
        check("rst_busy", busy16, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready16", in_ready16, 1'b1);
        check("rel_in_ready8", in_ready8, 1'b1);

        // 1234: fits the 16-bit build, too many digits for the 8-bit build
        send_stream(32'h1234F, 5);   collect(16'd1234, 0, 8'h00, 1);
        // -9999
        send_stream(32'hA9999F, 6);  collect(16'hD8F1, 0, 8'h00, 1);
        // lone Minus
        send_stream(32'hAF, 2);      collect(16'h0000, 1, 8'h00, 1);
        // 128 overflows +127 on 8 bits
        send_stream(32'h128F, 4);    collect(16'd128, 0, 8'h00, 1);
        // -128 is the 8-bit negative limit
        send_stream(32'hA128F, 5);   collect(16'hFF80, 0, 8'h80, 0);
        // -129 just past it
        send_stream(32'hA129F, 5);   collect(16'hFF7F, 0, 8'h00, 1);
        send_stream(32'h127F, 4);    collect(16'd127, 0, 8'd127, 0);
        // too many digits for both, busy held through DRAIN
        send_stream(32'h12345F, 6);  collect(16'h0000, 1, 8'h00, 1);
        // illegal symbol, late Minus
        send_stream(32'h1C3F, 4);    collect(16'h0000, 1, 8'h00, 1);
        send_stream(32'h1AF, 3);     collect(16'h0000, 1, 8'h00, 1);
        // leading zeros count as digits
        send_stream(32'h0042F, 5);   collect(16'd42, 0, 8'h00, 1);
        send_stream(32'h042F, 4);    collect(16'd42, 0, 8'd42, 0);
        // empty number and illegal first symbol
        send_stream(32'hF, 1);       collect(16'h0000, 1, 8'h00, 1);
        send_stream(32'hBF, 2);      collect(16'h0000, 1, 8'h00, 1);
        // 999 too large for 8 bits
        send_stream(32'h999F, 4);    collect(16'd999, 0, 8'h00, 1);

        // Result waits with out_ready low while a new symbol is offered.
        send_stream(32'h5F, 2);
        in_valid = 1'b1;
        in_digit = 4'h7;
        for (int i = 0; i < 10; i++) begin
            check("hold_in_ready", in_ready16, 1'b0);
            check("hold_out_valid", out_valid16, 1'b1);
            check("hold_value16", out_value16, 16'd5);
            check("hold_value8", out_value8, 8'd5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", out_valid16, 1'b0);
        check("rel_busy", busy16, 1'b0);
        check("rel_in_ready", in_ready16, 1'b1);
        @(negedge clk);
        check("seven_busy", busy16, 1'b1);
        in_digit = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        collect(16'd7, 0, 8'd7, 0);

        // Asynchronous reset in the middle of "5,6,7,F".
        @(negedge clk);
        in_valid = 1'b1;
        in_digit = 4'h5;
        @(negedge clk);
        in_digit = 4'h6;
        @(posedge clk);
        #1;
        check("pre_rst_busy", busy16, 1'b1);
        check("pre_rst_value", out_value16, 16'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid16, 1'b0);
        check("arst_out_value16", out_value16, 16'h0);
        check("arst_out_value8", out_value8, 8'h0);
        check("arst_out_error", out_error16, 1'b0);
        check("arst_busy16", busy16, 1'b0);
        check("arst_busy8", busy8, 1'b0);
        check("arst_in_ready", in_ready16, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_stream(32'h8F, 2);      collect(16'd8, 0, 8'd8, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
